fetch_queue: RTL and testbench

Instruction fetch queue between the fetch stage and the decode stage. Accepts one fetched instruction per cycle as an `if_id_reg_t` record (pc, inst, predicted_pc, prediction_valid, valid), buffers up to DEPTH records in FIFO order, and presents the oldest record to decode under a valid/ready handshake. This decouples Wishbone fetch latency from decode stalls. A flush discards all buffered records in one cycle.

---
 rtl/fetch_queue.sv | 77 +++++++
 tb/tb_fetch_queue.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between fetch and decode.
// Optional combinational bypass when empty: define FETCH_QUEUE_BYPASS_EN.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          discard all entries and suppress this cycle's push/pop
//   in_rec         record from fetch; in_rec.valid requests a push
//   in_ready       queue accepts a push this cycle (!full)
//   out_rec        oldest record; out_rec.valid offers a pop
//   out_ready      decode consumes out_rec this cycle
//   count          stored entries
//   full, empty    count == DEPTH, count == 0
package fetch_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] predicted_pc;
    logic        prediction_valid;
    logic        valid;
  } if_id_reg_t;
endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  if_id_reg_t               in_rec,
  output logic                     in_ready,
  output if_id_reg_t               out_rec,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  if_id_reg_t     r_mem [DEPTH];
  logic [AW:0]    r_wp, r_rp;
  logic           w_push, w_pop, w_byp;
  assign count    = r_wp - r_rp;
  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = count == '0;
  assign in_ready = !full;
`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue hands the incoming record straight to a ready decoder.
  assign w_byp = empty && in_rec.valid && out_ready && !flush;
`else
  assign w_byp = 1'b0;
`endif
  assign w_push = in_rec.valid && in_ready && !flush && !w_byp;
  assign w_pop  = !empty && out_ready && !flush;
  always_comb begin
    out_rec = (flush || empty) ? '0 : r_mem[r_rp[AW-1:0]];
`ifdef FETCH_QUEUE_BYPASS_EN
    // rst_n gating keeps out_rec at zero while reset is held.
    if (empty && in_rec.valid && !flush && rst_n) out_rec = in_rec;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end
  // Storage is never cleared; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= in_rec;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scoreboard bench for fetch_queue (DEPTH=4, no bypass).
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  localparam int DEPTH = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  if_id_reg_t in_rec = '0;
  if_id_reg_t out_rec;
  logic       in_ready, full, empty;
  logic [2:0] count;
  if_id_reg_t sb [$];
  int         total = 0;
  int         fails = 0;
  logic [31:0] next_pc = 32'h8000_0000;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_rec(in_rec), .in_ready(in_ready),
    .out_rec(out_rec), .out_ready(out_ready), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic fl, input logic ordy);
    in_rec = '0;
    if (v) begin
      in_rec.pc = next_pc;
      in_rec.inst = next_pc ^ 32'h0000_0013;
      in_rec.predicted_pc = next_pc + 32'd4;
      in_rec.prediction_valid = next_pc[2];
      in_rec.valid = 1'b1;
    end
    flush = fl;
    out_ready = ordy;
  endtask

  // One cycle: check mid-cycle outputs against the model, update the model, advance.
  task automatic tick();
    int n;
    if_id_reg_t e;
    @(negedge clk);
    n = sb.size();
    chk("count", 128'(count), 128'(n));
    chk("empty", 128'(empty), 128'(n == 0));
    chk("full", 128'(full), 128'(n == DEPTH));
    chk("in_ready", 128'(in_ready), 128'(n < DEPTH));
    if (flush || n == 0) chk("out_idle", 128'(out_rec), 128'(0));
    else chk("out_head", 128'(out_rec), 128'(sb[0]));
    if (flush) sb.delete();
    else begin
      if (n > 0 && out_ready) e = sb.pop_front();
      if (in_rec.valid && n < DEPTH) sb.push_back(in_rec);
    end
    @(posedge clk);
    #1;
    if (in_rec.valid && !flush && n < DEPTH) next_pc += 32'd4;
  endtask

  initial begin
    #2;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out", 128'(out_rec), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // two back-to-back pushes with decode ready
    drive(1, 0, 1); tick();
    drive(1, 0, 1); tick();
    drive(0, 0, 1); tick();
    tick();
    // fill with decode stalled, fifth push refused, then drain
    for (int i = 0; i < 5; i++) begin drive(1, 0, 0); tick(); end
    drive(0, 0, 1);
    for (int i = 0; i < 5; i++) tick();
    // full queue with push and pop in the same cycle
    for (int i = 0; i < 4; i++) begin drive(1, 0, 0); tick(); end
    drive(1, 0, 1); tick();
    drive(1, 0, 0); tick();
    drive(0, 0, 1);
    for (int i = 0; i < 5; i++) tick();
    // sustained push/pop to wrap both pointers repeatedly
    for (int i = 0; i < 20; i++) begin drive(1, 0, 1); tick(); end
    drive(0, 0, 1); tick();
    tick();
    // flush with three stored and a push pending
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0); tick(); end
    drive(1, 1, 1); tick();
    drive(1, 0, 1); tick();
    drive(0, 0, 1); tick();
    tick();
    // asynchronous reset mid-operation
    for (int i = 0; i < 2; i++) begin drive(1, 0, 0); tick(); end
    drive(0, 0, 0);
    #2;
    chk("pre_async_count", 128'(count), 128'(2));
    rst_n = 1'b0;
    #1;
    chk("async_count", 128'(count), 128'(0));
    chk("async_out", 128'(out_rec), 128'(0));
    chk("async_empty", 128'(empty), 128'(1));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 1); tick();
    drive(0, 0, 1); tick();
    tick();
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
